// File: rtl/spi_master_if.sv
// Command/response bundle between a bus requester and the SPI master.
// The requester drives commands; the SPI master answers with read data.
interface spi_master_if #(
   parameter int FRAME_WIDTH = 8
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [FRAME_WIDTH-1:0] cmd_data;
   logic                   rsp_valid;
   logic [FRAME_WIDTH-1:0] rsp_data;
   logic                   busy;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/spi_master.sv
// SPI master: frames {ctrl, payload} MSB first on MOSI, one bit per clk.
// Read-data frames wait RD_WAIT cycles, then shift a byte in from MISO.
module spi_master #(
   parameter int FRAME_WIDTH = 8,
   parameter int CTRL_WIDTH  = 3,
   parameter int RD_WAIT     = 1,
   parameter int IDLE_GAP    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_master_if.slave  bus,
   output logic         SS_n,
   output logic         MOSI,
   input  logic         MISO
);

   localparam int LEN    = CTRL_WIDTH + FRAME_WIDTH;
   localparam int SPAN_A = (LEN > FRAME_WIDTH + RD_WAIT) ?
                           LEN : FRAME_WIDTH + RD_WAIT;
   localparam int SPAN   = (SPAN_A > IDLE_GAP) ? SPAN_A : IDLE_GAP;
   localparam int CW     = $clog2(SPAN + 1);

   typedef enum logic [2:0] {
      IDLE, START, SHIFT, WAIT, CAPTURE, GAP
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [LEN-1:0]         sh_q, sh_d;
   logic                   rd_q, rd_d;
   logic [FRAME_WIDTH-1:0] cap_q, cap_d;
   logic                   ss_q, ss_d;
   logic                   mosi_q, mosi_d;
   logic                   rdy_q, rdy_d;
   logic                   busy_q, busy_d;
   logic                   rv_q, rv_d;
   logic [FRAME_WIDTH-1:0] rdata_q, rdata_d;
   logic                   done;
   logic [CTRL_WIDTH-1:0]  ctrl;

   // 00->0..00, 01->0..01, 10->1..10, 11->1..11
   assign ctrl = {{(CTRL_WIDTH-1){bus.cmd_op[1]}}, bus.cmd_op[0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      rd_d    = rd_q;
      cap_d   = cap_q;
      ss_d    = ss_q;
      mosi_d  = mosi_q;
      rdata_d = rdata_q;
      rv_d    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid && rdy_q) begin
               state_d = START;
               sh_d    = {ctrl, bus.cmd_data};
               rd_d    = &bus.cmd_op;
               ss_d    = 1'b0;
               mosi_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         START: begin
            state_d = SHIFT;
            mosi_d  = sh_q[LEN-1];
            sh_d    = sh_q << 1;
            cnt_d   = CW'(1);
         end
         SHIFT: begin
            if (cnt_q == CW'(LEN)) begin
               mosi_d = 1'b0;
               cnt_d  = '0;
               if (!rd_q)
                  done = 1'b1;
               else
                  state_d = (RD_WAIT > 0) ? WAIT : CAPTURE;
            end else begin
               mosi_d = sh_q[LEN-1];
               sh_d   = sh_q << 1;
               cnt_d  = cnt_q + CW'(1);
            end
         end
         WAIT: begin
            if (cnt_q == CW'(RD_WAIT - 1)) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CAPTURE: begin
            cap_d = {cap_q[FRAME_WIDTH-2:0], MISO};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(FRAME_WIDTH - 1)) begin
               rdata_d = {cap_q[FRAME_WIDTH-2:0], MISO};
               rv_d    = 1'b1;
               done    = 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == CW'(IDLE_GAP - 2))
               state_d = IDLE;
            else
               cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
      // The first idle cycle doubles as the last SS_n-high gap cycle.
      if (done) begin
         ss_d    = 1'b1;
         mosi_d  = 1'b0;
         cnt_d   = '0;
         state_d = (IDLE_GAP > 1) ? GAP : IDLE;
      end
      rdy_d  = (state_d == IDLE);
      busy_d = !rdy_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         rd_q    <= 1'b0;
         cap_q   <= '0;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         rd_q    <= rd_d;
         cap_q   <= cap_d;
         ss_q    <= ss_d;
         mosi_q  <= mosi_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         rv_q    <= rv_d;
         rdata_q <= rdata_d;
      end
   end

   assign SS_n          = ss_q;
   assign MOSI          = mosi_q;
   assign bus.cmd_ready = rdy_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rv_q;
   assign bus.rsp_data  = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: cycle model, RAM-backed SPI slave and directed
// vectors with hand-computed frames, gaps and read-back bytes.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst_n;
   logic SS_n, MOSI, MISO;

   always #5 clk = ~clk;

   spi_master_if #(.FRAME_WIDTH(8)) bus();

   spi_master #(
      .FRAME_WIDTH(8), .CTRL_WIDTH(3), .RD_WAIT(1), .IDLE_GAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] ctrl_of(input logic [1:0] op);
      logic [2:0] tbl [4];
      tbl = '{3'b000, 3'b001, 3'b110, 3'b111};
      return tbl[op];
   endfunction

   // Model: mc = cycle index since acceptance, -1 when no frame is running.
   int         mc;
   logic [10:0] m_fr;
   logic       m_rd, m_rv;
   logic [7:0] m_cap, m_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc <= -1; m_fr <= '0; m_rd <= 1'b0;
         m_rv <= 1'b0; m_cap <= '0; m_rdata <= '0;
      end else if (mc < 0) begin
         m_rv <= 1'b0;
         if (bus.cmd_valid === 1'b1) begin
            m_fr <= {ctrl_of(bus.cmd_op), bus.cmd_data};
            m_rd <= (bus.cmd_op == 2'b11);
            mc   <= 0;
         end
      end else begin
         m_rv <= 1'b0;
         if (m_rd && mc >= 13 && mc <= 20)
            m_cap <= {m_cap[6:0], MISO};
         if (!m_rd && mc == 11) begin
            mc <= -1;
         end else if (m_rd && mc == 20) begin
            mc      <= -1;
            m_rv    <= 1'b1;
            m_rdata <= {m_cap[6:0], MISO};
         end else begin
            mc <= mc + 1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("ss_n",      32'(SS_n),          32'(mc < 0));
         chk("mosi",      32'(MOSI),
             (mc >= 1 && mc <= 11) ? 32'(m_fr[11-mc]) : 32'd0);
         chk("cmd_ready", 32'(bus.cmd_ready), 32'(mc < 0));
         chk("busy",      32'(bus.busy),      32'(mc >= 0));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
         chk("rsp_data",  32'(bus.rsp_data),  32'(m_rdata));
      end
   end

   // RAM-backed slave plus an optional forced MISO pattern.
   logic [7:0]  smem [256];
   logic [7:0]  refm [256];
   int          sn = 0;
   logic [10:0] sfr = '0;
   logic [7:0]  s_wa = '0, s_ra = '0, s_out = '0;
   logic        s_miso = 1'b0;
   bit          force_en = 0;
   logic [7:0]  pat = 8'hB2;

   initial forever begin
      @(negedge clk);
      if (SS_n === 1'b0) begin
         sn = sn + 1;
         if (sn >= 2 && sn <= 12) sfr = {sfr[9:0], MOSI};
         if (sn == 12 && sfr[10:8] == 3'b111) s_out = smem[s_ra];
         s_miso = (sn >= 14 && sn <= 21) ? s_out[21-sn] : 1'b0;
      end else begin
         if (sn >= 12) begin
            case (sfr[10:8])
               3'b000:  s_wa = sfr[7:0];
               3'b001:  smem[s_wa] = sfr[7:0];
               3'b110:  s_ra = sfr[7:0];
               default: ;
            endcase
         end
         sn = 0;
         s_miso = 1'b0;
      end
      if (!force_en)
         MISO = s_miso;
      else if (mc >= 13 && mc <= 20)
         MISO = pat[20-mc];
      else
         MISO = (mc == 11 || mc == 12 || mc < 0);
   end

   // SS_n run-length monitor.
   logic        prev = 1'b1;
   int          lo_len = 0, hi_len = 0, last_len = 0;
   logic [31:0] bits = '0, last_bits = '0;
   int          hi_q [$];

   initial forever begin
      @(negedge clk);
      if (SS_n === 1'b0) begin
         if (prev) begin
            hi_q.push_back(hi_len);
            lo_len = 0;
            bits = '0;
         end
         lo_len++;
         bits = {bits[30:0], MOSI};
         prev = 1'b0;
      end else begin
         if (!prev) begin
            last_len = lo_len;
            last_bits = bits;
            hi_len = 0;
         end
         hi_len++;
         prev = 1'b1;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [7:0] d);
      int t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      while (bus.cmd_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bus.cmd_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("idle", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
   endtask

   initial begin
      int cyc, sz;
      logic [7:0] a, d;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 8'h00;
      MISO  = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         smem[i] = 8'h00;
         refm[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk("rst_ss_n",  32'(SS_n),          32'd1);
      chk("rst_mosi",  32'(MOSI),          32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_rv",    32'(bus.rsp_valid), 32'd0);
      chk("rst_rd",    32'(bus.rsp_data),  32'd0);
      #2 rst_n = 1'b1;
      cmp_en = 1;
      @(negedge clk);

      issue(2'b00, 8'h3C);
      wait_idle();
      #1;
      chk("wa_len",  32'(last_len),        32'd12);
      chk("wa_bits", 32'(last_bits[11:0]), 32'h03C);
      @(negedge clk);

      issue(2'b00, 8'hA5);
      issue(2'b01, 8'h5A);
      issue(2'b10, 8'hA5);
      issue(2'b11, 8'hFF);
      wait_rsp(cyc);
      chk("rd_lat",  32'(cyc),           32'd21);
      chk("rd_data", 32'(bus.rsp_data),  32'h5A);
      @(negedge clk);
      chk("rd_pulse", 32'(bus.rsp_valid), 32'd0);
      chk("rd_hold",  32'(bus.rsp_data),  32'h5A);
      refm[8'hA5] = 8'h5A;
      wait_idle();

      force_en = 1;
      issue(2'b11, 8'h00);
      wait_rsp(cyc);
      #1;
      chk("forced",    32'(bus.rsp_data), 32'hB2);
      chk("model_pin", 32'(m_rdata),      32'hB2);
      @(negedge clk);
      force_en = 0;
      wait_idle();

      sz = hi_q.size();
      bus.cmd_op    = 2'b01;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 45; i++) begin
         bus.cmd_data = 8'(i * 7 + 3);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      wait_idle();
      #1;
      chk("b2b_frames", 32'(hi_q.size() - sz), 32'd4);
      for (int k = 1; k < 4; k++)
         if (sz + k < hi_q.size())
            chk("b2b_gap", 32'(hi_q[sz+k]), 32'd1);
      chk("b2b_last", 32'(last_bits[11:0]), 32'h114);
      @(negedge clk);

      issue(2'b01, 8'h77);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ss_n", 32'(SS_n),          32'd1);
      chk("mid_mosi", 32'(MOSI),          32'd0);
      chk("mid_rv",   32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_ready", 32'(bus.cmd_ready), 32'd1);
      issue(2'b00, 8'h01);
      wait_idle();
      #1;
      chk("post_len",  32'(last_len),        32'd12);
      chk("post_bits", 32'(last_bits[11:0]), 32'h001);
      @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         a = 8'($urandom);
         d = 8'($urandom);
         issue(2'b00, a);
         issue(2'b01, d);
         refm[a] = d;
         a = 8'($urandom_range(0, 3)) ^ a;
         issue(2'b10, a);
         issue(2'b11, 8'($urandom));
         wait_rsp(cyc);
         chk("readback", 32'(bus.rsp_data), 32'(refm[a]));
         wait_idle();
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
